dlx_gpr_env: RTL and testbench



---
 rtl/dlx_pkg.sv | 13 +
 rtl/dlx_gpr_env_if.sv | 26 ++
 rtl/dlx_gpr_array.sv | 27 ++
 rtl/dlx_gpr_env.sv | 88 ++++++++
 tb/tb_dlx_gpr_env.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/dlx_pkg.sv
// rtl/dlx_pkg.sv - shared widths and state encoding for the DLX GPR environment
package dlx_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef enum logic {
    GPR_INIT  = 1'b0,
    GPR_READY = 1'b1
  } gpr_state_e;

endpackage

// File: rtl/dlx_gpr_env_if.sv
// rtl/dlx_gpr_env_if.sv - read/write/latch bus between control and the GPR environment
interface dlx_gpr_env_if;
  import dlx_pkg::*;

  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              gpr_we;
  logic              a_ce;
  logic              b_ce;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              aeqz;
  logic              ready;

  modport master (
    output rs1_addr, rs2_addr, wr_addr, wr_data, gpr_we, a_ce, b_ce,
    input  a_q, b_q, aeqz, ready
  );

  modport slave (
    input  rs1_addr, rs2_addr, wr_addr, wr_data, gpr_we, a_ce, b_ce,
    output a_q, b_q, aeqz, ready
  );
endinterface

// File: rtl/dlx_gpr_array.sv
// rtl/dlx_gpr_array.sv - unreset register storage, one sync write port, two async read ports
module dlx_gpr_array
  import dlx_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  // No reset here so the array can map onto LUT-RAM; the top clears it by sweeping.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: rtl/dlx_gpr_env.sv
// rtl/dlx_gpr_env.sv - GPR file with init sweep, R0 masking, write-first bypass and A/B operand latches
module dlx_gpr_env
  import dlx_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  dlx_gpr_env_if.slave  bus
);

  gpr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, b_q, a_d, b_d;

  logic              arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rd1, arr_rd2;
  logic [DATA_W-1:0] rd1, rd2;
  logic              wb_valid;

  dlx_gpr_array u_array (
    .clk    (clk),
    .we     (arr_we),
    .waddr  (arr_waddr),
    .wdata  (arr_wdata),
    .raddr1 (bus.rs1_addr),
    .raddr2 (bus.rs2_addr),
    .rdata1 (arr_rd1),
    .rdata2 (arr_rd2)
  );

  assign wb_valid = bus.gpr_we && (bus.wr_addr != '0);

  // R0 is forced to zero on read; a same-cycle write-back wins over the array.
  assign rd1 = (bus.rs1_addr == '0) ? '0 :
               (wb_valid && bus.rs1_addr == bus.wr_addr) ? bus.wr_data : arr_rd1;
  assign rd2 = (bus.rs2_addr == '0) ? '0 :
               (wb_valid && bus.rs2_addr == bus.wr_addr) ? bus.wr_data : arr_rd2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= GPR_INIT;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    arr_we    = 1'b0;
    arr_waddr = bus.wr_addr;
    arr_wdata = bus.wr_data;
    case (state_q)
      GPR_INIT: begin
        arr_we    = 1'b1;
        arr_waddr = cnt_q;
        arr_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        a_d       = '0;
        b_d       = '0;
        if (cnt_q == ADDR_W'(NUM_REGS - 1)) begin
          state_d = GPR_READY;
        end
      end
      GPR_READY: begin
        arr_we = wb_valid;
        if (bus.a_ce) a_d = rd1;
        if (bus.b_ce) b_d = rd2;
      end
      default: state_d = GPR_INIT;
    endcase
  end

  assign bus.a_q   = a_q;
  assign bus.b_q   = b_q;
  assign bus.aeqz  = ~|a_q;
  assign bus.ready = (state_q == GPR_READY);

endmodule

// File: tb/tb_dlx_gpr_env.sv
// tb/tb_dlx_gpr_env.sv - directed self-checking bench for dlx_gpr_env
module tb_dlx_gpr_env;
  import dlx_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  dlx_gpr_env_if bus ();

  dlx_gpr_env dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.gpr_we   = 1'b0;
    bus.a_ce     = 1'b0;
    bus.b_ce     = 1'b0;
    bus.rs1_addr = '0;
    bus.rs2_addr = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
    idle();
    bus.gpr_we  = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    step();
    idle();
  endtask

  task automatic load_ab(input logic [2:0] ra, input logic [2:0] rb);
    idle();
    bus.a_ce     = 1'b1;
    bus.b_ce     = 1'b1;
    bus.rs1_addr = ra;
    bus.rs2_addr = rb;
    step();
    idle();
  endtask

  // Assumes rst_n was just released before the first edge of the sweep.
  task automatic sweep_check(input string tag);
    for (int i = 1; i < 8; i++) begin
      step();
      check({tag, "_ready_low"}, {31'b0, bus.ready}, 32'd0);
    end
    step();
    check({tag, "_ready_high"}, {31'b0, bus.ready}, 32'd1);
  endtask

  initial begin
    idle();
    rst_n        = 1'b0;
    bus.gpr_we   = 1'b1;
    bus.a_ce     = 1'b1;
    bus.b_ce     = 1'b1;
    bus.rs1_addr = 3'd3;
    bus.rs2_addr = 3'd3;
    bus.wr_addr  = 3'd3;
    bus.wr_data  = 32'hFFFF_FFFF;
    step();
    step();
    check("rst_a_q", bus.a_q, 32'd0);
    check("rst_b_q", bus.b_q, 32'd0);
    check("rst_aeqz", {31'b0, bus.aeqz}, 32'd1);
    check("rst_ready", {31'b0, bus.ready}, 32'd0);

    // Controls held active throughout INIT must have no effect.
    rst_n = 1'b1;
    for (int i = 1; i < 8; i++) begin
      step();
      check("init_ready_low", {31'b0, bus.ready}, 32'd0);
      check("init_a_q", bus.a_q, 32'd0);
      check("init_b_q", bus.b_q, 32'd0);
      check("init_aeqz", {31'b0, bus.aeqz}, 32'd1);
    end
    step();
    check("init_ready_high", {31'b0, bus.ready}, 32'd1);
    check("init_end_a_q", bus.a_q, 32'd0);
    idle();
    load_ab(3'd3, 3'd3);
    check("init_r3_cleared", bus.a_q, 32'd0);

    write_reg(3'd3, 32'h0000_00A5);
    load_ab(3'd3, 3'd0);
    check("wr_rd_a_q", bus.a_q, 32'h0000_00A5);
    check("wr_rd_aeqz", {31'b0, bus.aeqz}, 32'd0);
    check("wr_rd_b_r0", bus.b_q, 32'd0);

    write_reg(3'd0, 32'hFFFF_FFFF);
    load_ab(3'd0, 3'd0);
    check("r0_a_q", bus.a_q, 32'd0);
    check("r0_b_q", bus.b_q, 32'd0);
    check("r0_aeqz", {31'b0, bus.aeqz}, 32'd1);

    // Same-cycle write to R0 must not bypass into the latches.
    bus.gpr_we = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 32'hDEAD_BEEF;
    bus.a_ce = 1'b1; bus.rs1_addr = 3'd0;
    step();
    idle();
    check("r0_bypass_a_q", bus.a_q, 32'd0);

    bus.gpr_we = 1'b1; bus.wr_addr = 3'd5; bus.wr_data = 32'h1234_5678;
    bus.a_ce = 1'b1; bus.rs1_addr = 3'd5;
    bus.b_ce = 1'b1; bus.rs2_addr = 3'd5;
    step();
    idle();
    check("bypass_a_q", bus.a_q, 32'h1234_5678);
    check("bypass_b_q", bus.b_q, 32'h1234_5678);
    load_ab(3'd0, 3'd5);
    check("bypass_stored_b_q", bus.b_q, 32'h1234_5678);

    write_reg(3'd2, 32'd7);
    load_ab(3'd2, 3'd0);
    check("hold_load_a", bus.a_q, 32'd7);
    for (int i = 0; i < 10; i++) begin
      bus.gpr_we = 1'b1; bus.wr_addr = 3'd2; bus.wr_data = 32'd9;
      step();
    end
    idle();
    check("hold_a_q", bus.a_q, 32'd7);
    bus.b_ce = 1'b1; bus.rs2_addr = 3'd2;
    step();
    idle();
    check("indep_b_q", bus.b_q, 32'd9);
    check("indep_a_q", bus.a_q, 32'd7);

    write_reg(3'd6, 32'h0000_0055);
    write_reg(3'd7, 32'h0000_00AA);
    load_ab(3'd6, 3'd7);
    check("pre_rst_r6", bus.a_q, 32'h0000_0055);
    check("pre_rst_r7", bus.b_q, 32'h0000_00AA);

    rst_n = 1'b0;
    step();
    check("rdy_rst_a_q", bus.a_q, 32'd0);
    check("rdy_rst_b_q", bus.b_q, 32'd0);
    check("rdy_rst_ready", {31'b0, bus.ready}, 32'd0);
    rst_n = 1'b1;
    sweep_check("rdy_rst");
    load_ab(3'd6, 3'd7);
    check("rdy_rst_r6", bus.a_q, 32'd0);
    check("rdy_rst_r7", bus.b_q, 32'd0);

    // Interrupt a sweep at cnt=4 with stale data left in R6/R7.
    write_reg(3'd6, 32'h0000_0055);
    write_reg(3'd7, 32'h0000_00AA);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("mid_sweep_ready", {31'b0, bus.ready}, 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    sweep_check("mid_rst");
    load_ab(3'd6, 3'd7);
    check("mid_rst_r6", bus.a_q, 32'd0);
    check("mid_rst_r7", bus.b_q, 32'd0);
    check("mid_rst_aeqz", {31'b0, bus.aeqz}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
